// File: rtl/steer_en.sv
// steer_en: rider-presence and balance qualifier that enables steering.
//   Waits in WAIT until the rider has stood balanced for a full timer period,
//   then enables steering. It leaves steering on dismount or a heavy lean.
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   lft_ld_i     left load-cell reading, unsigned, unregistered
//   rght_ld_i    right load-cell reading, unsigned, unregistered
//   en_steer_o   high while in STEER
//   rider_off_o  high while in IDLE
module steer_en #(
  parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
  parameter logic [11:0] WT_HYSTERESIS = 12'h040,  // must be below MIN_RIDER_WT
  parameter bit          FAST_SIM      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_ld_i,
  input  logic [11:0] rght_ld_i,
  output logic        en_steer_o,
  output logic        rider_off_o
);

  localparam int unsigned LD_W  = 12;
  localparam int unsigned SUM_W = 13;
  localparam int unsigned TMR_W = FAST_SIM ? 15 : 26;

  localparam logic [SUM_W-1:0] WT_HI = SUM_W'(MIN_RIDER_WT) + SUM_W'(WT_HYSTERESIS);
  localparam logic [SUM_W-1:0] WT_LO = SUM_W'(MIN_RIDER_WT) - SUM_W'(WT_HYSTERESIS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STEER = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              tmr_clr;
  logic              en_steer_q, en_steer_d;
  logic              rider_off_q, rider_off_d;

  logic [SUM_W-1:0]        sum_c;
  logic signed [SUM_W-1:0] sdiff_c;
  logic [LD_W-1:0]         diff_c;
  logic                    sum_gt_min, sum_lt_min;
  logic                    diff_gt_1_4, diff_gt_15_16;
  logic                    tmr_full;

  // Load-cell sum and absolute difference (13-bit, no overflow loss)
  assign sum_c   = {1'b0, lft_ld_i} + {1'b0, rght_ld_i};
  assign sdiff_c = $signed({1'b0, lft_ld_i}) - $signed({1'b0, rght_ld_i});
  assign diff_c  = sdiff_c[SUM_W-1] ? LD_W'(-sdiff_c) : sdiff_c[LD_W-1:0];

  // Threshold compares; equality never counts as exceeded
  assign sum_gt_min    = sum_c > WT_HI;
  assign sum_lt_min    = sum_c < WT_LO;
  assign diff_gt_1_4   = {1'b0, diff_c} > (sum_c >> 2);
  assign diff_gt_15_16 = {1'b0, diff_c} > (sum_c - (sum_c >> 4));
  assign tmr_full      = &tmr_q;

  // State, timer and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      en_steer_q  <= en_steer_d;
      rider_off_q <= rider_off_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sum_gt_min) begin
          state_d = ST_WAIT;
          tmr_clr = 1'b1;
        end
      end
      ST_WAIT: begin
        if (sum_lt_min)       state_d = ST_IDLE;
        else if (diff_gt_1_4) tmr_clr = 1'b1;
        else if (tmr_full)    state_d = ST_STEER;
      end
      ST_STEER: begin
        if (sum_lt_min) begin
          state_d = ST_IDLE;
        end else if (diff_gt_15_16) begin
          state_d = ST_WAIT;
          tmr_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timer counts only while staying in WAIT; zero everywhere else, so it never wraps
  always_comb begin
    tmr_d = '0;
    if (state_q == ST_WAIT && state_d == ST_WAIT && !tmr_clr) tmr_d = tmr_q + TMR_W'(1);
  end

  // Moore outputs, decoded from next state so they flip with the state register
  always_comb begin
    en_steer_d  = 1'b0;
    rider_off_d = 1'b0;
    if (state_d == ST_STEER) en_steer_d  = 1'b1;
    if (state_d == ST_IDLE)  rider_off_d = 1'b1;
  end

  assign en_steer_o  = en_steer_q;
  assign rider_off_o = rider_off_q;

endmodule

// File: doc/steer_en.md
STEER_EN -- requirements
Module: steer_en

Interface
REQ-001 Parameter MIN_RIDER_WT, default 12'h200, nominal rider-present threshold on load-cell sum.
REQ-002 Parameter WT_HYSTERESIS, default 12'h040, half-width of the presence hysteresis band; MIN_RIDER_WT SHALL exceed WT_HYSTERESIS.
REQ-003 Parameter FAST_SIM, default 0, selects a 15-bit balance timer (1) instead of a 26-bit timer (0).
REQ-004 clk  input  1  system clock, 50 MHz, all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 lft_ld  input  12  left load-cell reading (unsigned), from the A2D interface.
REQ-007 rght_ld  input  12  right load-cell reading (unsigned), from the A2D interface.
REQ-008 en_steer  output  1  high while steering is enabled.
REQ-009 rider_off  output  1  high while no rider is detected.

Function
REQ-010 sum SHALL be the 13-bit unsigned lft_ld + rght_ld, computed combinationally every cycle, with no overflow loss.
REQ-011 diff SHALL be the 12-bit |lft_ld - rght_ld|, computed through a 13-bit signed subtraction.
REQ-012 sum_gt_min SHALL be sum > (MIN_RIDER_WT + WT_HYSTERESIS), strict compare.
REQ-013 sum_lt_min SHALL be sum < (MIN_RIDER_WT - WT_HYSTERESIS), strict compare.
REQ-014 diff_gt_1_4 SHALL be diff > (sum >> 2), truncating, strict.
REQ-015 diff_gt_15_16 SHALL be diff > (sum - (sum >> 4)), truncating, strict.
REQ-016 The balance timer SHALL be 26 bits (FAST_SIM=0) or 15 bits (FAST_SIM=1); tmr_full SHALL be asserted when the count is all-ones.
REQ-017 The timer SHALL hold 0 outside WAIT.
REQ-018 In WAIT, the timer SHALL increment by 1 per cycle unless cleared; it SHALL never wrap, because WAIT exits on tmr_full.
REQ-019 The FSM SHALL have exactly three states: IDLE, WAIT, STEER.
REQ-020 IDLE: if sum_gt_min, go to WAIT with the timer cleared; otherwise stay in IDLE.
REQ-021 WAIT, in priority order:
- sum_lt_min: go to IDLE.
- else diff_gt_1_4: clear the timer and stay in WAIT.
- else tmr_full: go to STEER.
- else: stay in WAIT and count.
REQ-022 STEER, in priority order:
- sum_lt_min: go to IDLE.
- else diff_gt_15_16: go to WAIT with the timer cleared.
- else: stay in STEER.
REQ-023 en_steer SHALL be a Moore output, high if and only if state==STEER.
REQ-024 rider_off SHALL be a Moore output, high if and only if state==IDLE.
REQ-025 Latency: each transition SHALL take effect on the first rising clk edge at which its condition is true; outputs SHALL change in that same cycle with no further pipeline delay.
REQ-026 With balanced load, en_steer SHALL rise exactly 2^N clocks after the first cycle in WAIT (N = timer width).
REQ-027 A sum inside the hysteresis band (sum_lt_min=0 and sum_gt_min=0) SHALL cause no state change in any state.
REQ-028 Equality at any threshold SHALL count as not exceeded.
REQ-029 The inputs SHALL be treated as unregistered and level-sensitive; the block SHALL not depend on A2D update timing.

Reset
REQ-030 While rst_n=0 at a rising clk edge, the block SHALL set state=IDLE and timer=0, giving en_steer=0 and rider_off=1.
REQ-031 Reset SHALL take priority over all transitions, including mid-WAIT and mid-STEER.
REQ-032 Outputs SHALL not change asynchronously on rst_n.

Verification (FAST_SIM=1, default parameters: upper threshold 0x240, lower threshold 0x1C0)
REQ-033 Reset: assert rst_n=0 for 2 clocks with any inputs -> en_steer=0, rider_off=1 at the following edge.
REQ-034 Mount balanced: lft=rght=0x200 from IDLE.
- rider_off falls 1 clk later (WAIT).
- en_steer rises exactly 32768 clks after WAIT entry.
REQ-035 Imbalance in WAIT: lft=0x300, rght=0x100 (diff 0x200 > 0x100) held for 40000 clks -> en_steer stays 0; then lft=rght=0x200 -> en_steer rises 32768 clks later.
REQ-036 Edge of imbalance: lft=0x280, rght=0x180 (diff 0x100 == sum>>2) -> timer not cleared; en_steer rises on schedule.
REQ-037 Heavy lean in STEER: lft=0x3F8, rght=0x008 (diff 0x3F0 > 0x3C0) -> en_steer=0 next clk, rider_off stays 0 (WAIT).
REQ-038 Dismount and hysteresis in STEER:
- sum=0x1C0 for 100 clks -> stays in STEER.
- sum=0x1BF -> en_steer=0 and rider_off=1 next clk.
- rst_n=0 mid-WAIT -> IDLE; a re-mount then takes a full 32768 clks.
